// File: rtl/uart_phy_lite_if.sv
// uart_phy_lite_if: byte-level TX/RX handshake and status pulses between the UART register block and the PHY.
interface uart_phy_lite_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;
  modport slave (input tx_data, tx_valid, rx_ready, output tx_ready, rx_data, rx_valid, rx_frame_err, rx_overrun);
  modport master (output tx_data, tx_valid, rx_ready, input tx_ready, rx_data, rx_valid, rx_frame_err, rx_overrun);
endinterface

// File: rtl/uart_phy_lite.sv
// uart_phy_lite: 8N1 UART PHY serialising bytes onto uart_tx and deserialising uart_rx into a held byte.
module uart_phy_lite #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic            clka,
  input  logic            rstn,
  uart_phy_lite_if.slave  bus,
  output logic            uart_tx,
  input  logic            uart_rx
);
  localparam int DIVISOR = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(DIVISOR + 1);
  localparam logic [CW-1:0] DIV = CW'(DIVISOR);
  localparam logic [CW-1:0] HALF = CW'(DIVISOR / 2);
  localparam logic [CW-1:0] CNT1 = CW'(1);
  if (DIVISOR < 4) begin : g_div_chk
    $error("uart_phy_lite: DIVISOR must be >= 4");
  end
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t          tx_st_q;
  logic [CW-1:0]   tx_cnt_q;
  logic [2:0]      tx_idx_q;
  logic [7:0]      tx_sh_q;
  logic            tx_q;
  logic            tx_ready_q;
  // Each phase lasts exactly DIVISOR edges: loaded with DIVISOR, transitions when it reads 1.
  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      tx_st_q    <= IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      case (tx_st_q)
        IDLE: if (bus.tx_valid) begin
          tx_st_q    <= START;
          tx_cnt_q   <= DIV;
          tx_sh_q    <= bus.tx_data;
          tx_q       <= 1'b0;
          tx_ready_q <= 1'b0;
        end
        START: if (tx_cnt_q == CNT1) begin
          tx_st_q  <= DATA;
          tx_cnt_q <= DIV;
          tx_idx_q <= '0;
          tx_q     <= tx_sh_q[0];
        end else tx_cnt_q <= tx_cnt_q - 1'b1;
        DATA: if (tx_cnt_q == CNT1) begin
          tx_st_q  <= (tx_idx_q == 3'd7) ? STOP : DATA;
          tx_cnt_q <= DIV;
          tx_idx_q <= tx_idx_q + 1'b1;
          tx_sh_q  <= tx_sh_q >> 1;
          tx_q     <= (tx_idx_q == 3'd7) ? 1'b1 : tx_sh_q[1];
        end else tx_cnt_q <= tx_cnt_q - 1'b1;
        default: if (tx_cnt_q == CNT1) begin
          tx_st_q    <= IDLE;
          tx_ready_q <= 1'b1;
        end else tx_cnt_q <= tx_cnt_q - 1'b1;
      endcase
    end
  end
  logic [1:0]      sync_q;
  logic            rxs;
  state_t          rx_st_q;
  logic [CW-1:0]   rx_cnt_q;
  logic [2:0]      rx_idx_q;
  logic [7:0]      rx_sh_q;
  logic [7:0]      rx_data_q;
  logic            rx_valid_q;
  logic            ferr_q;
  logic            ovr_q;
  assign rxs = sync_q[1];
  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) sync_q <= 2'b11;
    else sync_q <= {sync_q[0], uart_rx};
  end
  // Returning to IDLE at mid-stop leaves half a bit to catch the next start edge.
  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      rx_st_q    <= IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      if (rx_valid_q && bus.rx_ready) rx_valid_q <= 1'b0;
      case (rx_st_q)
        IDLE: if (!rxs) begin
          rx_st_q  <= START;
          rx_cnt_q <= HALF;
        end
        START: if (rx_cnt_q == CNT1) begin
          rx_st_q  <= rxs ? IDLE : DATA;
          rx_cnt_q <= DIV;
          rx_idx_q <= '0;
        end else rx_cnt_q <= rx_cnt_q - 1'b1;
        DATA: if (rx_cnt_q == CNT1) begin
          rx_st_q  <= (rx_idx_q == 3'd7) ? STOP : DATA;
          rx_cnt_q <= DIV;
          rx_idx_q <= rx_idx_q + 1'b1;
          rx_sh_q  <= {rxs, rx_sh_q[7:1]};
        end else rx_cnt_q <= rx_cnt_q - 1'b1;
        default: if (rx_cnt_q == CNT1) begin
          rx_st_q <= IDLE;
          if (!rxs) ferr_q <= 1'b1;
          else if (!rx_valid_q || bus.rx_ready) begin
            rx_data_q  <= rx_sh_q;
            rx_valid_q <= 1'b1;
          end else ovr_q <= 1'b1;
        end else rx_cnt_q <= rx_cnt_q - 1'b1;
      endcase
    end
  end
  assign uart_tx          = tx_q;
  assign bus.tx_ready     = tx_ready_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.rx_frame_err = ferr_q;
  assign bus.rx_overrun   = ovr_q;
endmodule

// File: doc/uart_phy_lite.md
Name: uart_phy_lite

Overview:
- 8N1 UART physical layer that sits directly below the SRAM-mapped UART register block.
- TX path: accepts a byte on the tx_data/tx_valid/tx_ready handshake and serialises it onto uart_tx.
- RX path: deserialises uart_rx and presents the byte on rx_data/rx_valid/rx_ready.
- Also reports frame-error and overrun pulses for debug or status use.

Parameters:
- CLK_FREQ, 50000000, clka frequency in Hz.
- BAUD_RATE, 115200, line bit rate.
- DIVISOR, CLK_FREQ/BAUD_RATE (truncated integer), clka cycles per bit. Must be >= 4; otherwise a static assertion fails at elaboration.

Ports:
- clka, input, 1, system clock; all logic is on the rising edge.
- rstn, input, 1, asynchronous active-low reset.
- tx_data, input, 8, byte to transmit.
- tx_valid, input, 1, tx_data is valid this cycle.
- tx_ready, output, 1, transmitter idle and able to accept.
- rx_data, output, 8, last received byte.
- rx_valid, output, 1, rx_data holds an unconsumed byte.
- rx_ready, input, 1, consumer accepts rx_data this cycle.
- uart_tx, output, 1, serial line out; idles high.
- uart_rx, input, 1, serial line in; asynchronous to clka.
- rx_frame_err, output, 1, one-cycle pulse when a stop bit is sampled low.
- rx_overrun, output, 1, one-cycle pulse when a received byte is dropped.

Behaviour:
- Reset is asynchronous, active-low, and applies the following values:
  - uart_tx=1, tx_ready=1, rx_valid=0, rx_data=0, rx_frame_err=0, rx_overrun=0.
  - TX and RX state machines return to IDLE.
  - Baud counters are cleared.
  - Both synchroniser flops are set to 1.
- Reset asserted mid-frame aborts the frame immediately: uart_tx goes high asynchronously and no partial byte is delivered.
- All outputs are registered.
- TX state machine, states IDLE -> START -> DATA -> STOP -> IDLE:
  - tx_ready=1 only in IDLE.
  - A byte is accepted on any edge where tx_valid && tx_ready; tx_data is latched into a shift register.
  - Accept at edge N gives uart_tx=0 and tx_ready=0 from edge N+1.
  - START drives uart_tx=0 for DIVISOR cycles.
  - DATA drives 8 bits, LSB first, DIVISOR cycles each; a 3-bit counter tracks the bit index.
  - STOP drives uart_tx=1 for DIVISOR cycles.
  - At the end of STOP the machine returns to IDLE and tx_ready=1. Total frame length is 10*DIVISOR cycles.
  - tx_valid while tx_ready=0 is ignored; the byte is lost, and upstream is responsible for that.
  - tx_valid may be a single-cycle pulse. The handshake needs only one cycle of overlap.
- RX synchroniser: uart_rx passes through 2 flops; all RX logic uses the synchronised value rxs.
- RX state machine, states IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: rxs==0 moves to START and loads the counter with DIVISOR/2.
  - START: at count expiry rxs is re-sampled.
    - rxs==1 is a false start: return to IDLE with no pulse.
    - rxs==0 goes to DATA, counter reloaded with DIVISOR.
  - DATA: sample rxs at each DIVISOR expiry, shifting in LSB first; after 8 samples go to STOP.
  - STOP: sample at DIVISOR expiry.
    - rxs==1: deliver the byte (see below).
    - rxs==0: pulse rx_frame_err for one cycle, discard the byte. rx_valid and rx_data are unchanged.
    - In both cases return to IDLE at the mid-stop sample so that back-to-back frames resynchronise.
- Byte delivery:
  - If rx_valid==0, or rx_valid && rx_ready in that same cycle: rx_data <= byte and rx_valid <= 1 on that edge.
  - Otherwise the new byte is dropped, rx_overrun pulses for one cycle, and the old rx_data and rx_valid are held.
- rx_valid clears on the edge where rx_valid && rx_ready, unless a new byte is delivered on the same edge.
- rx_data is stable while rx_valid=1.
- TX and RX are fully independent; simultaneous activity is allowed.
- Counter widths are $clog2(DIVISOR+1). There is no wrap-around beyond the reload value.

Test Plan:
Use CLK_FREQ=1000000 and BAUD_RATE=100000, giving DIVISOR=10.
- TX single byte: tx_valid pulse with tx_data=0xA5 at edge N.
  - tx_ready=0 from N+1.
  - uart_tx bit periods (10 cycles each) are 0,1,0,1,0,0,1,0,1,1.
  - tx_ready=1 at N+101.
- TX busy: pulse tx_valid with 0x11, then pulse again with 0x22 at N+5 -> the second byte is ignored and only the 0x11 frame appears; after tx_ready returns, 0x22 is accepted normally.
- RX loopback: uart_tx tied to uart_rx, send 0x3C with rx_ready=1 -> rx_valid pulses for exactly one cycle with rx_data=0x3C, about 95 cycles after the start edge; no error pulses.
- RX overrun: rx_ready=0, inject frames 0x55 then 0x66 -> rx_data=0x55 and rx_valid held; rx_overrun pulses once at the mid-stop of 0x66; raising rx_ready then clears rx_valid.
- Frame error and glitch:
  - Inject 0x81 with the stop bit forced 0 -> rx_frame_err pulses once and rx_valid stays 0.
  - Inject a 3-cycle low glitch on uart_rx -> no pulse, RX remains IDLE.
- Reset mid-frame: assert rstn low 40 cycles into a TX frame of 0xFF -> uart_tx=1 and tx_ready=1 immediately; after release, a new byte 0x0F transmits a clean full frame.
